// File: rtl/stop_watch_ctrl.sv
// Stopwatch/timer sequencing controller.
// Five raw buttons are synchronised and debounced into one-cycle command pulses.
// A state machine turns those commands into timer controls. It also handles lap
// freeze on the display and the countdown-expiry alarm.
module stop_watch_ctrl #(
  parameter int DB_CYCLES    = 20,
  parameter int ALARM_CYCLES = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        btn_lap,
  input  logic        btn_clear,
  input  logic        btn_preset,
  input  logic        btn_dir,
  input  logic [15:0] tmr_digits,
  output logic        tmr_reset,
  output logic        tmr_set,
  output logic        tmr_pause,
  output logic        tmr_up,
  output logic [15:0] disp,
  output logic        alarm,
  output logic [2:0]  state
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int ALM_W = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [ALM_W-1:0] ALM_MAX = ALM_W'(ALARM_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_PAUSED = 3'd2,
    S_LAP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Button bit order: 0 clear, 1 start, 2 lap, 3 preset, 4 dir (lower index wins)
  logic [4:0]       btn_raw;
  logic [4:0]       sync_p0;
  logic [4:0]       sync_p1;
  logic [4:0]       acc_lvl;
  logic [CNT_W-1:0] db_cnt [5];
  logic [4:0]       cmd_p2;

  logic             do_clear, do_start, do_lap, do_preset, do_dir;
  logic             expired;

  state_t           st;
  logic [15:0]      lap_latch;
  logic [ALM_W-1:0] alm_cnt;

  assign btn_raw = {btn_dir, btn_preset, btn_lap, btn_start, btn_clear};

  // Synchroniser, debounce counter and rising-edge command pulse per button
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      acc_lvl <= '0;
      cmd_p2  <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      cmd_p2  <= '0;
      for (int i = 0; i < 5; i++) begin
        if (sync_p1[i] == acc_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_MAX) begin
          // DB_CYCLES consecutive differing samples: accept new level
          acc_lvl[i] <= sync_p1[i];
          db_cnt[i]  <= '0;
          cmd_p2[i]  <= sync_p1[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Same-cycle commands resolve to the single highest-priority one
  assign do_clear  = cmd_p2[0];
  assign do_start  = cmd_p2[1] & ~cmd_p2[0];
  assign do_lap    = cmd_p2[2] & ~(|cmd_p2[1:0]);
  assign do_preset = cmd_p2[3] & ~(|cmd_p2[2:0]);
  assign do_dir    = cmd_p2[4] & ~(|cmd_p2[3:0]);

  assign expired = ~tmr_up && (tmr_digits == 16'h0000);

  assign state = st;

  // Control state machine with registered timer controls, display and alarm
  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= S_IDLE;
      tmr_pause <= 1'b1;
      tmr_up    <= 1'b1;
      tmr_reset <= 1'b0;
      tmr_set   <= 1'b0;
      alarm     <= 1'b0;
      alm_cnt   <= '0;
      disp      <= 16'h0000;
      lap_latch <= 16'h0000;
    end else begin
      tmr_reset <= 1'b0;
      tmr_set   <= 1'b0;
      disp      <= tmr_digits;
      if (do_clear) begin
        tmr_reset <= 1'b1;
        alarm     <= 1'b0;
        tmr_pause <= 1'b1;
        st        <= S_IDLE;
      end else begin
        case (st)
          S_IDLE: begin
            if (do_start) begin
              // a countdown already at zero has nothing to run
              if (!expired) begin
                st        <= S_RUN;
                tmr_pause <= 1'b0;
              end
            end else if (do_preset) begin
              tmr_set <= 1'b1;
            end else if (do_dir) begin
              tmr_up <= ~tmr_up;
            end
          end
          S_RUN, S_LAP: begin
            if (expired) begin
              st        <= S_DONE;
              tmr_pause <= 1'b1;
              alarm     <= 1'b1;
              alm_cnt   <= ALM_MAX;
            end else if (do_start) begin
              st        <= S_PAUSED;
              tmr_pause <= 1'b1;
            end else if (do_lap) begin
              if (st == S_RUN) begin
                lap_latch <= tmr_digits;
                st        <= S_LAP;
              end else begin
                st <= S_RUN;
              end
            end else if (st == S_LAP) begin
              disp <= lap_latch;
            end
          end
          S_PAUSED: begin
            if (do_start) begin
              st        <= S_RUN;
              tmr_pause <= 1'b0;
            end
          end
          S_DONE: begin
            if (alarm) begin
              if (alm_cnt == '0) alarm   <= 1'b0;
              else               alm_cnt <= alm_cnt - ALM_W'(1);
            end
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

endmodule
